fpu_result_sat: RTL and testbench
=================================

Name: fpu_result_sat

Overview:
- Output stage directly downstream of the fixed-point unit. Accepts the 40-bit add/sub result plus its 4-bit op select.
- Saturates the result to a 32-bit signed word and flags overflow.
- Buffers results in a small FIFO behind a valid/ready handshake, so a stalled consumer does not drop results.
- Keeps a sticky, saturating overflow event counter for software/debug.

Parameters:
- IN_W, 40, width of the incoming result (two's complement signed).
- OUT_W, 32, width of the saturated output word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept a result this cycle.
- in_data  input  IN_W  result from the fixed-point unit, signed.
- in_sel  input  4  op select that produced in_data; carried through unchanged.
- out_valid  output  1  head FIFO entry valid.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  OUT_W  saturated result.
- out_ovf  output  1  head entry was saturated.
- out_sel  output  4  op select of the head entry.
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  number of accepted results that saturated.

Behaviour:
- Reset (rst=1 at a clock edge): FIFO count, read pointer and write pointer = 0; out_valid=0; ovf_count=0. rst overrides all other inputs that cycle. Entries in flight are discarded, including mid-stall.
- Push: in_valid && in_ready at an edge.
- Pop: out_valid && out_ready at an edge.
- in_ready = (count < DEPTH), registered-state only. There is no pass-through when full: with full && out_ready, in_ready stays 0 that cycle.
- Saturation is combinational on in_data before the FIFO write. MAX = 2^(OUT_W-1)-1; MIN = -2^(OUT_W-1).
  - in_data > MAX: store MAX (0x7FFFFFFF), ovf=1.
  - in_data < MIN: store MIN (0x80000000), ovf=1.
  - Otherwise: store in_data[OUT_W-1:0], ovf=0.
- Each entry stores {sel, ovf, data}.
- Latency: a result pushed at edge N has out_valid=1 from edge N onward if the FIFO was empty (one cycle input-to-output). No combinational path from in_* to out_*.
- out_valid = (count != 0). out_data, out_ovf and out_sel show the head entry. All three read as 0 when out_valid=0.
- Holding: while out_valid && !out_ready, out_* stay stable.
- Simultaneous push and pop: allowed when 0 < count < DEPTH; count is unchanged and both pointers advance.
- Boundary cases:
  - Push when full: cannot occur (in_ready=0); in_valid is ignored.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- Ordering: strict FIFO.
- ovf_count:
  - Increments by 1 on each push with ovf=1.
  - Saturates at all-ones; it does not wrap.
  - clr_count=1 sets it to 0. If clr_count and an overflowing push occur in the same cycle, the result is 1.
  - Popping has no effect on ovf_count.
- in_sel is not interpreted, only carried through.

Test Plan:
1. Reset, then push in_data=0x00_0000_0005, sel=ADD, out_ready=1 → out_valid=1 next cycle, out_data=0x00000005, out_ovf=0, out_sel=ADD, ovf_count=0.
2. Push 0x00_8000_0000 (+2^31), then 0xFF_7FFF_FFFF (-2^31-1) → out_data 0x7FFFFFFF ovf=1, then 0x80000000 ovf=1; ovf_count=2. Boundaries 0x00_7FFF_FFFF and 0xFF_8000_0000 pass unsaturated with ovf=0.
3. Hold out_ready=0 and push 4 values 1..4 → in_ready=0 after the 4th; a 5th in_valid is ignored. Raise out_ready → pops 1,2,3,4 in order; in_ready=1 the cycle after the first pop; out_* stable during the stall.
4. Continuous in_valid=1 and out_ready=1 for 20 cycles with incrementing data → one result per cycle, count stays 1, pointers wrap, no loss or reorder.
5. Preload ovf_count near saturation (CNT_W small, or force) → stays at all-ones. clr_count=1 with an overflowing push in the same cycle → ovf_count=1. clr_count alone → 0.
6. With 3 entries queued, assert rst for one cycle → next cycle out_valid=0, in_ready=1, ovf_count=0, out_data=0. The next push then appears normally.

Source files
------------

// File: rtl/fpu_result_sat_if.sv
// Handshake bundle between the fixed-point unit, this output stage and its consumer.
// The slave modport is the output stage's view; the master modport is the
// view of whoever drives the upstream results and consumes the outputs.
interface fpu_result_sat_if #(
   parameter int IN_W  = 40,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [3:0]       in_sel;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;
   logic [3:0]       out_sel;

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_sel
   );

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_sel
   );
endinterface

// File: rtl/fpu_result_sat.sv
// Output stage for the fixed-point unit: saturates the wide add/sub result to a
// signed word, queues {sel, ovf, data} in a small FIFO behind valid/ready, and
// keeps a sticky saturating count of overflowing results.
module fpu_result_sat #(
   parameter int IN_W  = 40,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   fpu_result_sat_if.slave  bus,
   input  logic             clr_count,
   output logic [CNT_W-1:0] ovf_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 4 + 1 + OUT_W;
   localparam int UPR_W = IN_W - OUT_W + 1;

   logic [PTR_W:0]         count_reg;
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [CNT_W-1:0]       ovf_cnt_reg;

   logic                   push;
   logic                   pop;
   logic [UPR_W-1:0]       upper_bits;
   logic                   in_range;
   logic                   sat_ovf;
   logic [OUT_W-1:0]       sat_data;
   logic [ENT_W-1:0]       wr_entry;
   logic [ENT_W-1:0]       head_entry;
   logic [DEPTH*ENT_W-1:0] entries_flat;

   // Handshake state depends only on registered occupancy: no in_* to out_* path.
   assign bus.in_ready  = (count_reg < (PTR_W+1)'(DEPTH));
   assign bus.out_valid = (count_reg != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // The value fits the output word only when every bit from the output sign bit
   // upward is a copy of the input sign bit; otherwise clamp toward that sign.
   assign upper_bits = bus.in_data[IN_W-1:OUT_W-1];
   assign in_range   = (upper_bits == '0) || (upper_bits == '1);
   assign sat_ovf    = !in_range;

   // Select the clamped or truncated word for the FIFO write.
   always_comb begin
      sat_data = bus.in_data[OUT_W-1:0];
      if (!in_range) begin
         if (bus.in_data[IN_W-1])
            sat_data = {1'b1, {(OUT_W-1){1'b0}}};
         else
            sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   assign wr_entry = {bus.in_sel, sat_ovf, sat_data};

   // One register slot per FIFO entry; storage is not reset because occupancy
   // alone decides what is visible.
   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ENT_W-1:0] entry_reg;

      // Capture the saturated result when this slot is the write target.
      always_ff @(posedge clk) begin
         if (push && (wr_ptr_reg == PTR_W'(gi)))
            entry_reg <= wr_entry;
      end

      assign entries_flat[gi*ENT_W +: ENT_W] = entry_reg;
   end

   assign head_entry = entries_flat[int'(rd_ptr_reg)*ENT_W +: ENT_W];

   // Head entry is masked to zero while the FIFO is empty.
   assign bus.out_data = bus.out_valid ? head_entry[OUT_W-1:0]         : '0;
   assign bus.out_ovf  = bus.out_valid ? head_entry[OUT_W]             : 1'b0;
   assign bus.out_sel  = bus.out_valid ? head_entry[OUT_W+4:OUT_W+1]   : 4'd0;

   // Pointer and occupancy bookkeeping; power-of-two depth gives natural wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Sticky overflow counter: clear wins over history but still counts a
   // same-cycle overflowing push; it sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt_reg <= '0;
      end else if (clr_count) begin
         ovf_cnt_reg <= {{(CNT_W-1){1'b0}}, push && sat_ovf};
      end else if (push && sat_ovf && (ovf_cnt_reg != {CNT_W{1'b1}})) begin
         ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
      end
   end

   assign ovf_count = ovf_cnt_reg;
endmodule

// File: tb/tb_fpu_result_sat.sv
// Bench for fpu_result_sat: hand-written vector table for saturation corners,
// a reference saturation function for streamed data, and a scoreboard queue
// checked against the FIFO head every cycle.
module tb_fpu_result_sat;
   localparam int IN_W  = 40;
   localparam int OUT_W = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct packed {
      logic [3:0]  sel;
      logic        ovf;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [39:0] din;
      logic [3:0]  sel;
      logic [31:0] exp_data;
      logic        exp_ovf;
   } vec_t;

   logic             clk;
   logic             rst;
   logic             clr_count;
   logic [CNT_W-1:0] ovf_count;

   fpu_result_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   fpu_result_sat #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clr_count (clr_count),
      .ovf_count (ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   ent_t model_q[$];
   int   mcnt = 0;
   vec_t vecs[10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ent_t sat_model(input logic [39:0] d, input logic [3:0] s);
      longint v;
      ent_t   e;
      v = longint'($signed(d));
      e.sel = s;
      if (v > SMAX) begin
         e.data = 32'h7FFF_FFFF; e.ovf = 1'b1;
      end else if (v < SMIN) begin
         e.data = 32'h8000_0000; e.ovf = 1'b1;
      end else begin
         e.data = d[31:0]; e.ovf = 1'b0;
      end
      return e;
   endfunction

   // Check DUT state against the model at the falling edge, then advance the
   // model by whatever the upcoming rising edge will do.
   task automatic tick(input ent_t exp_in);
      logic do_push, do_pop;
      @(negedge clk);
      check("in_ready",  bus.in_ready,  model_q.size() < DEPTH);
      check("out_valid", bus.out_valid, model_q.size() != 0);
      check("ovf_count", ovf_count, mcnt);
      if (model_q.size() != 0) begin
         check("out_data", bus.out_data, model_q[0].data);
         check("out_ovf",  bus.out_ovf,  model_q[0].ovf);
         check("out_sel",  bus.out_sel,  model_q[0].sel);
      end else begin
         check("idle_data", bus.out_data, 0);
         check("idle_ovf",  bus.out_ovf,  0);
         check("idle_sel",  bus.out_sel,  0);
      end
      do_push = bus.in_valid && (model_q.size() < DEPTH);
      do_pop  = bus.out_ready && (model_q.size() != 0);
      if (rst) begin
         model_q.delete();
         mcnt = 0;
         $display("reset");
      end else begin
         if (do_pop) begin
            $display("pop  data=%08h ovf=%0d sel=%0d", model_q[0].data, model_q[0].ovf, model_q[0].sel);
            void'(model_q.pop_front());
         end
         if (do_push) model_q.push_back(exp_in);
         if (clr_count)
            mcnt = (do_push && exp_in.ovf) ? 1 : 0;
         else if (do_push && exp_in.ovf && mcnt != (1 << CNT_W) - 1)
            mcnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [39:0] d, input logic [3:0] s, input logic rdy, input logic clr);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_sel    = s;
      bus.out_ready = rdy;
      clr_count     = clr;
      tick(sat_model(d, s));
   endtask

   initial begin
      ent_t e;
      vecs[0] = '{40'h00_0000_0005, 4'd1, 32'h0000_0005, 1'b0};
      vecs[1] = '{40'h00_8000_0000, 4'd2, 32'h7FFF_FFFF, 1'b1};
      vecs[2] = '{40'hFF_7FFF_FFFF, 4'd3, 32'h8000_0000, 1'b1};
      vecs[3] = '{40'h00_7FFF_FFFF, 4'd4, 32'h7FFF_FFFF, 1'b0};
      vecs[4] = '{40'hFF_8000_0000, 4'd5, 32'h8000_0000, 1'b0};
      vecs[5] = '{40'hFF_FFFF_FFFF, 4'd6, 32'hFFFF_FFFF, 1'b0};
      vecs[6] = '{40'h7F_FFFF_FFFF, 4'd7, 32'h7FFF_FFFF, 1'b1};
      vecs[7] = '{40'h80_0000_0000, 4'd8, 32'h8000_0000, 1'b1};
      vecs[8] = '{40'h01_0000_0000, 4'd9, 32'h7FFF_FFFF, 1'b1};
      vecs[9] = '{40'hFE_FFFF_FFFF, 4'hF, 32'h8000_0000, 1'b1};

      rst = 1'b1; clr_count = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Saturation table, one push and pop per cycle.
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1; bus.in_data = vecs[i].din; bus.in_sel = vecs[i].sel;
         bus.out_ready = 1'b1; clr_count = 1'b0;
         e.sel = vecs[i].sel; e.ovf = vecs[i].exp_ovf; e.data = vecs[i].exp_data;
         tick(e);
      end
      drive(1'b0, '0, 4'd0, 1'b1, 1'b0);
      check("ovf_count_after_table", ovf_count, 4'd6);

      // Stall: fill with 1..4, 5th ignored while full, also while full and draining.
      for (int i = 1; i <= 4; i++) drive(1'b1, 40'(i), 4'(i), 1'b0, 1'b0);
      check("full_in_ready", bus.in_ready, 1'b0);
      drive(1'b1, 40'd5, 4'd5, 1'b0, 1'b0);
      drive(1'b1, 40'd5, 4'd5, 1'b0, 1'b0);
      drive(1'b1, 40'd5, 4'd5, 1'b1, 1'b0);
      check("ready_after_first_pop", bus.in_ready, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 4'd0, 1'b1, 1'b0);

      // Streaming: 20 back-to-back transfers, pointers wrap several times.
      for (int i = 0; i < 20; i++) drive(1'b1, 40'(100 + i), 4'(i), 1'b1, 1'b0);
      drive(1'b0, '0, 4'd0, 1'b1, 1'b0);

      // Counter saturation, then clear with a coincident overflow, then clear alone.
      for (int i = 0; i < 12; i++) drive(1'b1, 40'h01_0000_0000, 4'hA, 1'b1, 1'b0);
      drive(1'b0, '0, 4'd0, 1'b1, 1'b0);
      check("ovf_count_saturated", ovf_count, 4'hF);
      drive(1'b1, 40'hF0_0000_0000, 4'hB, 1'b1, 1'b1);
      check("clr_with_ovf", ovf_count, 4'd1);
      drive(1'b0, '0, 4'd0, 1'b1, 1'b1);
      check("clr_alone", ovf_count, 4'd0);

      // Reset mid-stall with three entries queued.
      drive(1'b1, 40'h00_8000_0000, 4'd1, 1'b0, 1'b0);
      drive(1'b1, 40'd7, 4'd2, 1'b0, 1'b0);
      drive(1'b1, 40'd8, 4'd3, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b0, '0, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      check("rst_ovf_count", ovf_count,     4'd0);
      check("rst_out_data",  bus.out_data,  32'd0);
      drive(1'b1, 40'h00_0000_0042, 4'd9, 1'b1, 1'b0);
      drive(1'b0, '0, 4'd0, 1'b1, 1'b0);
      drive(1'b0, '0, 4'd0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
